multimode_ff_bank: RTL and testbench

//   WIDTH-bit bank of run-time-configurable flip-flops. Each bit behaves as a D, T, JK or SR

---
 rtl/multimode_ff_bank.sv | 147 ++++++++++++++
 tb/tb_multimode_ff_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multimode_ff_bank.sv
// ---------------------------------------------------------------------------
// multimode_ff_bank
//   WIDTH-bit bank of run-time-configurable flip-flops. A single bank-wide
//   mode register makes every channel behave as a D, T, JK or SR flip-flop.
//   S=R=1 in SR mode is flagged per channel with sticky flags. A saturating
//   counter records how many cycles contained at least one such event.
//
// Parameters
//   WIDTH      number of flip-flop channels (>=1)
//   CNT_W      width of the illegal-event counter (>=1)
//   RST_VAL    value loaded into q on reset
//   SR_POLICY  S=R=1 action: 0 hold, 1 reset wins, 2 set wins
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset, highest priority
//   ce       in   1      clock enable for q update and illegal detection
//   mode_wr  in   1      mode register write strobe
//   mode_in  in   2      new mode: 0 D, 1 T, 2 JK, 3 SR
//   a        in   WIDTH  D / T / J / S per channel
//   b        in   WIDTH  K / R per channel (ignored in D and T modes)
//   err_clr  in   1      clears illegal flags and err_cnt
//   q        out  WIDTH  registered flip-flop state
//   q_bar    out  WIDTH  ~q
//   mode     out  2      current mode
//   illegal  out  WIDTH  sticky per-channel S=R=1 flags
//   err_cnt  out  CNT_W  saturating count of cycles with any illegal channel
// ---------------------------------------------------------------------------
module multimode_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             mode_wr,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0]       MODE_D  = 2'd0;
    localparam logic [1:0]       MODE_T  = 2'd1;
    localparam logic [1:0]       MODE_JK = 2'd2;
    localparam logic [1:0]       MODE_SR = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_illegal;
    logic [CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_evt;
    logic             w_any_evt;

    // Next-state of every channel under the mode currently held in r_mode
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (r_mode)
                MODE_D:  w_q_next[i] = a[i];
                MODE_T:  w_q_next[i] = a[i] ? ~r_q[i] : r_q[i];
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b00:   w_q_next[i] = r_q[i];
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b11:   w_q_next[i] = ~r_q[i];
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                MODE_SR: begin
                    case ({a[i], b[i]})
                        2'b00:   w_q_next[i] = r_q[i];
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b11: begin
                            if (SR_POLICY == 1) begin
                                w_q_next[i] = 1'b0;
                            end else if (SR_POLICY == 2) begin
                                w_q_next[i] = 1'b1;
                            end else begin
                                w_q_next[i] = r_q[i];
                            end
                        end
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                default: w_q_next[i] = r_q[i];
            endcase
        end
    end

    // Illegal S=R=1 detection, only meaningful while enabled in SR mode
    always_comb begin
        if (ce && (r_mode == MODE_SR)) begin
            w_evt = a & b;
        end else begin
            w_evt = {WIDTH{1'b0}};
        end
        w_any_evt = |w_evt;
    end

    // State registers; the q update uses the old mode even when mode_wr is set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RST_VAL;
            r_mode    <= MODE_D;
            r_illegal <= {WIDTH{1'b0}};
            r_err_cnt <= {CNT_W{1'b0}};
        end else begin
            if (mode_wr) begin
                r_mode <= mode_in;
            end
            if (ce) begin
                r_q <= w_q_next;
            end
            // A clear that coincides with a new event restarts from that event
            if (err_clr) begin
                r_illegal <= w_evt;
                r_err_cnt <= w_any_evt ? CNT_ONE : {CNT_W{1'b0}};
            end else begin
                r_illegal <= r_illegal | w_evt;
                if (w_any_evt && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + CNT_ONE;
                end
            end
        end
    end

    assign q       = r_q;
    assign q_bar   = ~r_q;
    assign mode    = r_mode;
    assign illegal = r_illegal;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_multimode_ff_bank
//   Three instances share one stimulus stream:
//     u0: RST_VAL=A5, CNT_W=2, SR_POLICY=0 (hold)
//     u1: RST_VAL=00, CNT_W=8, SR_POLICY=1 (reset wins)
//     u2: RST_VAL=FF, CNT_W=8, SR_POLICY=2 (set wins)
//   A behavioural model tracks each instance; a compare process checks all
//   outputs every falling edge, and directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       mode_wr = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       err_clr = 1'b0;

    logic [7:0] q0, q1, q2, qb0, qb1, qb2, il0, il1, il2;
    logic [1:0] md0, md1, md2;
    logic [1:0] cnt0;
    logic [7:0] cnt1, cnt2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state per instance
    int m_q[3];
    int m_ill[3];
    int m_cnt[3];
    int m_mode;
    int cmax[3]   = '{3, 255, 255};
    int policy[3] = '{0, 1, 2};
    int rstv[3]   = '{8'hA5, 8'h00, 8'hFF};

    always #5 clk = ~clk;

    multimode_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'hA5), .SR_POLICY(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q0), .q_bar(qb0), .mode(md0), .illegal(il0), .err_cnt(cnt0));

    multimode_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'h00), .SR_POLICY(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q1), .q_bar(qb1), .mode(md1), .illegal(il1), .err_cnt(cnt1));

    multimode_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'hFF), .SR_POLICY(2)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q2), .q_bar(qb2), .mode(md2), .illegal(il2), .err_cnt(cnt2));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the inputs sampled at that edge
    task automatic model_edge();
        int ev, nq, qv, both, av, bv;
        av = int'(a);
        bv = int'(b);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_q[k] = rstv[k];
                m_ill[k] = 0;
                m_cnt[k] = 0;
            end
            m_mode = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                qv = m_q[k];
                ev = (ce && m_mode == 3) ? (av & bv) : 0;
                if (ce) begin
                    case (m_mode)
                        0: nq = av;
                        1: nq = qv ^ av;
                        2: nq = (av & ~qv) | (~bv & qv);
                        default: begin
                            both = (policy[k] == 0) ? qv : ((policy[k] == 1) ? 0 : 255);
                            nq = (av & ~bv) | (qv & ~av & ~bv) | (av & bv & both);
                        end
                    endcase
                    m_q[k] = nq & 255;
                end
                if (err_clr) begin
                    m_ill[k] = ev;
                    m_cnt[k] = (ev != 0) ? 1 : 0;
                end else begin
                    m_ill[k] = m_ill[k] | ev;
                    if (ev != 0 && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (mode_wr) m_mode = int'(mode_in);
        end
    endtask

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0.q", int'(q0), m_q[0]);
            chk("u0.q_bar", int'(qb0), (~m_q[0]) & 255);
            chk("u0.mode", int'(md0), m_mode);
            chk("u0.illegal", int'(il0), m_ill[0]);
            chk("u0.err_cnt", int'(cnt0), m_cnt[0]);
            chk("u1.q", int'(q1), m_q[1]);
            chk("u1.q_bar", int'(qb1), (~m_q[1]) & 255);
            chk("u1.mode", int'(md1), m_mode);
            chk("u1.illegal", int'(il1), m_ill[1]);
            chk("u1.err_cnt", int'(cnt1), m_cnt[1]);
            chk("u2.q", int'(q2), m_q[2]);
            chk("u2.q_bar", int'(qb2), (~m_q[2]) & 255);
            chk("u2.mode", int'(md2), m_mode);
            chk("u2.illegal", int'(il2), m_ill[2]);
            chk("u2.err_cnt", int'(cnt2), m_cnt[2]);
        end
    end

    // One clock: drive inputs after a falling edge, update model at the rising edge
    task automatic step(input logic r, input logic e, input logic w, input logic [1:0] mi,
                        input logic [7:0] av, input logic [7:0] bv, input logic c);
        @(negedge clk);
        rst = r; ce = e; mode_wr = w; mode_in = mi; a = av; b = bv; err_clr = c;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    initial begin
        // 1: reset, with a mode write that reset must override
        step(1'b1, 1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0);
        chk_en = 1'b1;
        chk("lit reset q", int'(q0), 8'hA5);
        chk("lit reset q_bar", int'(qb0), 8'h5A);
        chk("lit reset mode", int'(md0), 0);
        chk("lit reset u2 q", int'(q2), 8'hFF);

        // 2: D mode, then hold with ce=0
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h3C, 8'h00, 1'b0);
        chk("lit D q", int'(q0), 8'h3C);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 1'b0);
        chk("lit D hold", int'(q1), 8'h3C);

        // 3: q=00, then mode write to T uses D that cycle, then T applies
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd1, 8'hFF, 8'h00, 1'b0);
        chk("lit modechg q", int'(q0), 8'hFF);
        chk("lit modechg mode", int'(md0), 1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h0F, 8'h00, 1'b0);
        chk("lit T q", int'(q0), 8'hF0);

        // 4: JK mode (write with ce=0 so q stays F0)
        step(1'b0, 1'b0, 1'b1, 2'd2, 8'hFF, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h0F, 8'hF0, 1'b0);
        chk("lit JK set/reset", int'(q0), 8'h0F);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
        chk("lit JK toggle", int'(q0), 8'hF0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        chk("lit JK hold", int'(q0), 8'hF0);

        // 5: SR mode; clear q, then S=81 R=01
        step(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h81, 8'h01, 1'b0);
        chk("lit SR q pol0", int'(q0), 8'h80);
        chk("lit SR q pol1", int'(q1), 8'h80);
        chk("lit SR q pol2", int'(q2), 8'h81);
        chk("lit SR illegal", int'(il0), 8'h01);
        chk("lit SR err_cnt", int'(cnt0), 1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h81, 8'h01, 1'b0);
        chk("lit SR ce0 cnt", int'(cnt0), 1);

        // 6: saturation after 5 more illegal cycles (CNT_W=2 in u0)
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'd0, 8'h01, 8'h01, 1'b0);
        end
        chk("lit sat u0", int'(cnt0), 3);
        chk("lit count u1", int'(cnt1), 6);
        // Multi-channel illegal cycle counts once
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h06, 8'h06, 1'b0);
        chk("lit multi-ch u1", int'(cnt1), 7);
        chk("lit sticky", int'(il1), 8'h07);
        // Clear with simultaneous event on bit7
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h80, 8'h80, 1'b1);
        chk("lit clr+evt illegal", int'(il0), 8'h80);
        chk("lit clr+evt cnt", int'(cnt0), 1);
        // Clear while disabled: event suppressed, so plain clear
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1);
        chk("lit clr illegal", int'(il0), 8'h00);
        chk("lit clr cnt", int'(cnt1), 0);
        // Illegal combination outside SR mode is not an event
        step(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
        chk("lit JK no evt", int'(cnt1), 0);
        // Back to D, then reset mid-run
        step(1'b0, 1'b1, 1'b1, 2'd0, 8'h5A, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h5A, 8'h00, 1'b0);
        chk("lit D again", int'(q2), 8'h5A);
        step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        chk("lit rst2 q", int'(q0), 8'hA5);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
